// File: rtl/distortion_stage.sv
// Resyncs the codec LR clock, captures one stereo frame, applies gain and a symmetric clip, and
// registers the DAC outputs. DISTORTION_SOFT_CLIP_EN swaps the hard clip for a soft knee.
module distortion_stage #(
  parameter int GAIN_W = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     lrclk,
  input  logic signed [15:0]       adc_left,
  input  logic signed [15:0]       adc_right,
  input  logic        [GAIN_W-1:0] gain,
  input  logic        [14:0]       threshold,
  input  logic                     bypass,
  output logic signed [15:0]       dac_left,
  output logic signed [15:0]       dac_right,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     overrun
);
  localparam int PW = GAIN_W + 17;
  localparam int SW = PW - 4;

  typedef enum logic [2:0] {IDLE, CAP, MUL_L, CLIP_L, MUL_R, CLIP_R, OUT} state_t;

  state_t                   state_q, state_d;
  logic                     sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic signed [15:0]       cap_left_q, cap_left_d, cap_right_q, cap_right_d;
  logic        [GAIN_W-1:0] cap_gain_q, cap_gain_d;
  logic        [14:0]       cap_thr_q, cap_thr_d;
  logic                     cap_bypass_q, cap_bypass_d;
  logic signed [SW-1:0]     scaled_q, scaled_d;
  logic signed [15:0]       res_left_q, res_left_d;
  logic signed [15:0]       dac_left_q, dac_left_d, dac_right_q, dac_right_d;
  logic                     sample_valid_q, sample_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     edge_det;
  logic signed [15:0]       mul_in, clip_in, clip_res;
  logic signed [PW-1:0]     product;

  function automatic logic signed [15:0] shape(input logic signed [SW-1:0] s,
                                               input logic        [14:0]   thr);
    logic signed [SW-1:0] pos_t;
`ifdef DISTORTION_SOFT_CLIP_EN
    logic signed [SW-1:0] mag;
    logic signed [SW-1:0] knee;
`endif
    pos_t = SW'($signed({1'b0, thr}));
`ifdef DISTORTION_SOFT_CLIP_EN
    mag = s[SW-1] ? -s : s;
    if (mag <= pos_t) return s[15:0];
    knee = pos_t + ((mag - pos_t) >>> 2);
    if (!s[SW-1]) return (knee > SW'(32767)) ? 16'sh7FFF : knee[15:0];
    return (knee > SW'(32768)) ? 16'sh8000 : 16'(-knee);
`else
    if (s > pos_t) return pos_t[15:0];
    if (s < -pos_t) return 16'(-pos_t);
    return s[15:0];
`endif
  endfunction

  assign edge_det = sync2_q & ~prev_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_det) state_d = CAP;
      CAP:     state_d = MUL_L;
      MUL_L:   state_d = CLIP_L;
      CLIP_L:  state_d = MUL_R;
      MUL_R:   state_d = CLIP_R;
      CLIP_R:  state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_in   = (state_q == MUL_R) ? cap_right_q : cap_left_q;
    product  = PW'(mul_in) * PW'($signed({1'b0, cap_gain_q}));
    clip_in  = (state_q == CLIP_R) ? cap_right_q : cap_left_q;
    clip_res = cap_bypass_q ? clip_in : shape(scaled_q, cap_thr_q);

    sync1_d        = lrclk;
    sync2_d        = sync1_q;
    prev_d         = sync2_q;
    cap_left_d     = cap_left_q;
    cap_right_d    = cap_right_q;
    cap_gain_d     = cap_gain_q;
    cap_thr_d      = cap_thr_q;
    cap_bypass_d   = cap_bypass_q;
    scaled_d       = scaled_q;
    res_left_d     = res_left_q;
    dac_left_d     = dac_left_q;
    dac_right_d    = dac_right_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;

    case (state_q)
      CAP: begin
        cap_left_d   = adc_left;
        cap_right_d  = adc_right;
        cap_gain_d   = gain;
        cap_thr_d    = threshold;
        cap_bypass_d = bypass;
      end
      MUL_L, MUL_R: scaled_d = SW'(product >>> 4);
      CLIP_L:       res_left_d = clip_res;
      // Both channels load together so the outputs never mix frames.
      CLIP_R: begin
        dac_left_d     = res_left_q;
        dac_right_d    = clip_res;
        sample_valid_d = 1'b1;
      end
      default: ;
    endcase

    if (edge_det && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      cap_left_q     <= '0;
      cap_right_q    <= '0;
      cap_gain_q     <= '0;
      cap_thr_q      <= '0;
      cap_bypass_q   <= 1'b0;
      scaled_q       <= '0;
      res_left_q     <= '0;
      dac_left_q     <= '0;
      dac_right_q    <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      cap_left_q     <= cap_left_d;
      cap_right_q    <= cap_right_d;
      cap_gain_q     <= cap_gain_d;
      cap_thr_q      <= cap_thr_d;
      cap_bypass_q   <= cap_bypass_d;
      scaled_q       <= scaled_d;
      res_left_q     <= res_left_d;
      dac_left_q     <= dac_left_d;
      dac_right_q    <= dac_right_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign dac_left     = dac_left_q;
  assign dac_right    = dac_right_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_distortion_stage.sv
// Bench for distortion_stage: fixed vector table, overrun/reset sequences, random frames vs model.
`timescale 1ns/1ps
module tb_distortion_stage;
  localparam int GAIN_W = 8;

  logic                     CLOCK_50 = 1'b0;
  logic                     reset_n  = 1'b0;
  logic                     lrclk    = 1'b0;
  logic                     bypass   = 1'b0;
  logic signed [15:0]       adc_left = '0, adc_right = '0;
  logic        [GAIN_W-1:0] gain      = '0;
  logic        [14:0]       threshold = '0;
  logic signed [15:0]       dac_left, dac_right;
  logic                     sample_valid, busy, overrun;

  int tests = 0;
  int fails = 0;

  distortion_stage #(.GAIN_W(GAIN_W)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .lrclk(lrclk),
    .adc_left(adc_left), .adc_right(adc_right), .gain(gain),
    .threshold(threshold), .bypass(bypass),
    .dac_left(dac_left), .dac_right(dac_right),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int l, r, g, th;
    bit byp;
    int el, er;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: scale by gain/16 with floor, then clip or soft-knee against the threshold.
  function automatic int ref_out(input int s, input int g, input int th, input bit byp);
    int sc;
`ifdef DISTORTION_SOFT_CLIP_EN
    int mag, k;
`endif
    if (byp) return s;
    sc = (s * g) >>> 4;
`ifdef DISTORTION_SOFT_CLIP_EN
    mag = (sc < 0) ? -sc : sc;
    if (mag <= th) return sc;
    k = th + (mag - th) / 4;
    if (sc > 0) return (k > 32767) ? 32767 : k;
    return (k > 32768) ? -32768 : -k;
`else
    if (sc > th) return th;
    if (sc < -th) return -th;
    return sc;
`endif
  endfunction

  task automatic drive(input int l, input int r, input int g, input int th, input bit byp);
    adc_left  = 16'(l);
    adc_right = 16'(r);
    gain      = GAIN_W'(g);
    threshold = 15'(th);
    bypass    = byp;
  endtask

  // lrclk rises just after a falling edge; the output lands 8 rising edges later.
  task automatic frame(input string name, input int l, input int r, input int g, input int th,
                       input bit byp, input int el, input int er);
    int cnt;
    @(negedge CLOCK_50);
    drive(l, r, g, th, byp);
    lrclk = 1'b1;
    cnt = 0;
    do begin
      @(posedge CLOCK_50);
      cnt++;
      @(negedge CLOCK_50);
    end while (!sample_valid && cnt < 20);
    check({name, " latency"}, cnt, 8);
    check({name, " left"}, dac_left, el);
    check({name, " right"}, dac_right, er);
    @(negedge CLOCK_50);
    check({name, " pulse width"}, int'(sample_valid), 0);
    check({name, " busy after"}, int'(busy), 0);
    lrclk = 1'b0;
    repeat (4) @(negedge CLOCK_50);
  endtask

  initial begin
    int held, pulses, l, r, g, th;
    bit byp;

    vecs[0] = '{1000, -1000, 'h20, 12000, 1'b0, 2000, -2000};
`ifdef DISTORTION_SOFT_CLIP_EN
    vecs[1] = '{10000, -10000, 'h20, 12000, 1'b0, 14000, -14000};
    vecs[2] = '{10000, -10000, 'h20, 0, 1'b0, 5000, -5000};
    vecs[5] = '{32767, -32768, 'hFF, 32767, 1'b0, 32767, -32768};
`else
    vecs[1] = '{10000, -10000, 'h20, 12000, 1'b0, 12000, -12000};
    vecs[2] = '{10000, -10000, 'h20, 0, 1'b0, 0, 0};
    vecs[5] = '{32767, -32768, 'hFF, 32767, 1'b0, 32767, -32767};
`endif
    vecs[3] = '{30000, -32768, 'h40, 100, 1'b1, 30000, -32768};
    vecs[4] = '{100, -32768, 'h10, 32767, 1'b0, 100, -32767};
    vecs[6] = '{-1, 3, 'h08, 100, 1'b0, -1, 1};

    repeat (3) @(negedge CLOCK_50);
    check("reset dac_left", dac_left, 0);
    check("reset dac_right", dac_right, 0);
    check("reset sample_valid", int'(sample_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(overrun), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    foreach (vecs[i])
      frame($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].g, vecs[i].th,
            vecs[i].byp, vecs[i].el, vecs[i].er);

    held = dac_right;
    repeat (10) @(negedge CLOCK_50);
    check("hold between frames", dac_right, held);
    check("no overrun yet", int'(overrun), 0);

    // Second rising lrclk lands 3 cycles after the first is detected; inputs change post-capture.
    @(negedge CLOCK_50);
    drive(4000, -300, 'h10, 32767, 1'b0);
    lrclk = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    lrclk = 1'b0;
    @(negedge CLOCK_50);
    lrclk = 1'b1;
    @(negedge CLOCK_50);
    drive(1234, 5678, 'h10, 32767, 1'b0);
    repeat (4) @(negedge CLOCK_50);
    check("ovr first valid", int'(sample_valid), 1);
    check("ovr first left", dac_left, 4000);
    check("ovr first right", dac_right, -300);
    check("ovr flag", int'(overrun), 1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLOCK_50);
      if (sample_valid) pulses++;
    end
    check("ovr second ignored", pulses, 0);
    lrclk = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    frame("after ovr", 1234, 5678, 'h10, 32767, 1'b0, 1234, 5678);
    check("ovr sticky", int'(overrun), 1);

    // Reset asserted while the FSM sits in MUL_R.
    @(negedge CLOCK_50);
    drive(7000, 7000, 'h10, 32767, 1'b0);
    lrclk = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    check("pre-reset busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid reset dac_left", dac_left, 0);
    check("mid reset dac_right", dac_right, 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset overrun", int'(overrun), 0);
    lrclk = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    frame("post reset", 500, 0, 'h10, 32767, 1'b0, 500, 0);

    for (int n = 0; n < 40; n++) begin
      l   = int'($urandom_range(65535)) - 32768;
      r   = int'($urandom_range(65535)) - 32768;
      g   = int'($urandom_range(255));
      th  = int'($urandom_range(32767));
      byp = ($urandom_range(7) == 0);
      frame($sformatf("rand%0d", n), l, r, g, th, byp,
            ref_out(l, g, th, byp), ref_out(r, g, th, byp));
    end
    check("final overrun", int'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
